// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: shared FSM state encoding and one-hot-to-index helper for the write arbiter
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index of the highest set bit; callers pass a one-hot vector, so it is the only set bit.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i])
                idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester after last_owner
//   req        : request vector
//   last_owner : index of the previous owner; the scan starts one above it
//   pick       : one-hot winner, all-zero when req is zero
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] pick
);

    logic [IW-1:0]        start;
    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] dbl_iso;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   iso;

    assign start   = (last_owner == IW'(NUM_REQ - 1)) ? '0 : last_owner + IW'(1);
    // Rotate so the scan start sits at bit 0, isolate the lowest set bit, rotate back.
    assign dbl_req = {req, req} >> start;
    assign rot     = dbl_req[NUM_REQ-1:0];
    assign iso     = rot & (~rot + NUM_REQ'(1));
    assign dbl_iso = {iso, iso} << start;
    assign pick    = dbl_iso[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
//   clk_in, rst_in  : write-domain clock, synchronous active-high reset
//   req_in/data_in/last_in : per-requester word valid, word, end-of-burst flag
//   full_in         : FIFO full; blocks every write
//   grant_out       : registered one-hot owner, busy_out : grant active
//   ack_out         : one-hot consume strobe, write_out/data_write_out : FIFO write port
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_in,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]       last_in,
    input  logic                     full_in,
    output logic [NUM_REQ-1:0]       grant_out,
    output logic [NUM_REQ-1:0]       ack_out,
    output logic                     write_out,
    output logic [WIDTH-1:0]         data_write_out,
    output logic                     busy_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_n, pick;
    logic [IW-1:0]      last_owner, last_owner_n;
    logic [BW-1:0]      beat, beat_n;
    logic               req_g, last_g, release_now;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (req_in),
        .last_owner (last_owner),
        .pick       (pick)
    );

    // grant_out is zero in IDLE, so the owner-masked terms are naturally zero there.
    assign req_g       = |(grant_out & req_in);
    assign last_g      = |(grant_out & last_in);
    assign write_out   = req_g & ~full_in;
    assign ack_out     = grant_out & {NUM_REQ{write_out}};
    assign busy_out    = (state == ST_GRANT);
    // Full stalls never release: req_g stays high and write_out is low.
    assign release_now = (write_out & (last_g | (beat == BW'(MAX_BURST - 1)))) | ~req_g;

    always_comb begin
        data_write_out = '0;
        for (int i = 0; i < NUM_REQ; i++)
            data_write_out = data_write_out | (grant_out[i] ? data_in[i*WIDTH +: WIDTH] : '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            grant_out  <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            beat       <= '0;
        end else begin
            state      <= state_n;
            grant_out  <= grant_n;
            last_owner <= last_owner_n;
            beat       <= beat_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant_out;
        last_owner_n = last_owner;
        beat_n       = beat;
        if (state == ST_IDLE) begin
            if (|req_in) begin
                state_n = ST_GRANT;
                grant_n = pick;
                beat_n  = '0;
            end
        end else if (release_now) begin
            state_n      = ST_IDLE;
            grant_n      = '0;
            last_owner_n = IW'(onehot_to_idx(32'(grant_out)));
            beat_n       = '0;
        end else if (write_out) begin
            beat_n = beat + BW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenarios plus randomized traffic checked against a cycle-level reference model
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b1111;
    logic [31:0] data = '0;
    logic [3:0]  last = '0;
    logic        full = 1'b0;
    logic [3:0]  grant, ack;
    logic        write, busy;
    logic [7:0]  dw;

    int checks = 0;
    int failures = 0;

    // Reference model: owner index (-1 when idle), previous owner, words taken this burst.
    int m_owner = -1;
    int m_last = 3;
    int m_beats = 0;

    logic [3:0] s_grant, e_ack;
    logic       s_write;
    logic [7:0] s_data;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_in         (req),
        .data_in        (data),
        .last_in        (last),
        .full_in        (full),
        .grant_out      (grant),
        .ack_out        (ack),
        .write_out      (write),
        .data_write_out (dw),
        .busy_out       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] eg;
        logic       ew;
        logic [7:0] ed;
        @(negedge clk);
        eg    = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        ew    = (m_owner >= 0) && req[m_owner] && !full;
        ed    = (m_owner >= 0) ? data[m_owner*8 +: 8] : 8'h00;
        e_ack = ew ? eg : 4'b0;
        s_grant = grant;
        s_write = write;
        s_data  = dw;
        chk("grant", grant, eg);
        chk("busy", busy, m_owner >= 0);
        chk("write", write, ew);
        chk("ack", ack, e_ack);
        chk("data", dw, ed);
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_last  = 3;
            m_beats = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++)
                if (m_owner < 0 && req[(m_last + k) % 4])
                    m_owner = (m_last + k) % 4;
            m_beats = 0;
        end else begin
            if (ew)
                m_beats++;
            if (!req[m_owner] || (ew && (last[m_owner] || m_beats == 4))) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        int writes;

        // Reset holds everything off even with all requesters asking.
        tick();
        tick();
        chk("reset_grant", s_grant, 4'b0000);
        chk("reset_write", s_write, 1'b0);
        chk("reset_data", s_data, 8'h00);
        rst = 1'b0;
        tick();

        // Round robin: 4-word bursts, one bubble between grants.
        for (int i = 1; i <= 21; i++) begin
            tick();
            exp_g = ((i - 1) % 5 == 4) ? 4'b0000 : 4'(1 << (((i - 1) / 5) % 4));
            chk("rr_grant", s_grant, exp_g);
            chk("rr_write", s_write, exp_g != 4'b0000);
        end
        req = 4'b0000;
        tick();
        tick();

        // Early last from requester 1, then re-grant after one idle cycle.
        req = 4'b0010;
        data[15:8] = 8'hA1;
        tick();
        tick();
        chk("early_grant", s_grant, 4'b0010);
        chk("early_data1", s_data, 8'hA1);
        data[15:8] = 8'hA2;
        last = 4'b0010;
        tick();
        chk("early_write2", s_write, 1'b1);
        chk("early_data2", s_data, 8'hA2);
        data[15:8] = 8'hA3;
        last = 4'b0000;
        tick();
        chk("early_idle", s_grant, 4'b0000);
        tick();
        chk("early_regrant", s_grant, 4'b0010);
        req = 4'b0000;
        tick();
        tick();

        // Full stall for 3 cycles after the 2nd word; burst still ends at 4 words.
        req = 4'b0001;
        data[7:0] = 8'h10;
        tick();
        writes = 0;
        for (int k = 1; k <= 8; k++) begin
            full = (k >= 3 && k <= 5);
            tick();
            writes += int'(s_write);
            if (full) begin
                chk("stall_write", s_write, 1'b0);
                chk("stall_grant", s_grant, 4'b0001);
            end
        end
        full = 1'b0;
        chk("stall_writes", writes, 4);
        chk("stall_release", s_grant, 4'b0000);
        req = 4'b0000;
        tick();
        tick();

        // Abandon: requester 2 drops after one word, requester 3 gets the port two cycles later.
        req = 4'b1100;
        data[23:16] = 8'hB1;
        tick();
        tick();
        chk("abandon_grant", s_grant, 4'b0100);
        req = 4'b1000;
        tick();
        chk("abandon_nowrite", s_write, 1'b0);
        tick();
        chk("abandon_idle", s_grant, 4'b0000);
        tick();
        chk("abandon_next", s_grant, 4'b1000);
        req = 4'b0000;
        tick();
        tick();

        // Reset during requester 2's 2nd word: that word is written, then requester 0 wins.
        req = 4'b0100;
        data[23:16] = 8'hC1;
        tick();
        tick();
        data[23:16] = 8'hC2;
        rst = 1'b1;
        tick();
        chk("rstmid_write", s_write, 1'b1);
        chk("rstmid_data", s_data, 8'hC2);
        rst = 1'b0;
        req = 4'b0101;
        tick();
        chk("rstmid_drop", s_grant, 4'b0000);
        tick();
        chk("rstmid_regrant", s_grant, 4'b0001);

        // Randomized traffic honouring the hold-until-ack handshake, with occasional abandons.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || e_ack[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    data[i*8 +: 8] = 8'($urandom);
                    last[i] = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            full = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
